// File: rtl/wb_controller_pkg.sv
// Shared types and sizes for the write-back controller slice.
package wb_controller_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int REG_DATA_W    = 32;
  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_controller_if.sv
// Pipeline-facing bundle of the write-back controller: result inputs,
// issue/decode scoreboard signals and the register-file write port.
interface wb_controller_if;
  import wb_controller_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [REG_DATA_W-1:0] alu_data;
  logic                  long_valid;
  logic                  long_ready;
  logic [REG_ADDR_W-1:0] long_addr;
  logic [REG_DATA_W-1:0] long_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_addr;
  logic [REG_ADDR_W-1:0] read_addr1;
  logic [REG_ADDR_W-1:0] read_addr2;
  logic                  stall;
  logic [31:0]           busy;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [REG_DATA_W-1:0] write_data;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  long_valid, long_addr, long_data,
    input  issue_valid, issue_addr, read_addr1, read_addr2,
    output long_ready, stall, busy,
    output reg_write, write_addr, write_data
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output long_valid, long_addr, long_data,
    output issue_valid, issue_addr, read_addr1, read_addr2,
    input  long_ready, stall, busy,
    input  reg_write, write_addr, write_data
  );

endinterface

// File: rtl/wb_controller_fifo.sv
// Synchronous FIFO buffering long-latency results until the write port is free.
module wb_fifo
  import wb_controller_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t push_entry_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  wb_entry_t        mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

endmodule

// File: rtl/wb_controller.sv
// Write-back controller: merges ALU and buffered long-latency results into one
// registered register-file write per cycle and tracks pending destinations.
module wb_controller
  import wb_controller_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  wb_controller_if.slave bus_if
);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  long_ready;
  wb_entry_t             fifo_head;
  wb_entry_t             long_entry;

  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [REG_DATA_W-1:0] write_data_q, write_data_d;
  logic [31:0]           busy_q, busy_d;

  assign long_entry = {bus_if.long_addr, bus_if.long_data};
  assign long_ready = ~rst & ~fifo_full;
  // The ALU owns the write port whenever it has a result; the FIFO only drains in idle slots.
  assign fifo_pop   = ~bus_if.alu_valid & ~fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (bus_if.long_valid & long_ready),
    .pop_i        (fifo_pop),
    .push_entry_i (long_entry),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (fifo_head)
  );

  always_comb begin
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    busy_d       = busy_q;
    if (bus_if.alu_valid) begin
      reg_write_d  = (bus_if.alu_addr != '0);
      write_addr_d = bus_if.alu_addr;
      write_data_d = bus_if.alu_data;
    end else if (fifo_pop) begin
      reg_write_d            = (fifo_head.addr != '0);
      write_addr_d           = fifo_head.addr;
      write_data_d           = fifo_head.data;
      busy_d[fifo_head.addr] = 1'b0;
    end
    // A fresh issue supersedes a retiring result to the same register.
    if (bus_if.issue_valid && (bus_if.issue_addr != '0)) begin
      busy_d[bus_if.issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus_if.long_ready = long_ready;
  assign bus_if.stall      = busy_q[bus_if.read_addr1] | busy_q[bus_if.read_addr2];
  assign bus_if.busy       = busy_q;
  assign bus_if.reg_write  = reg_write_q;
  assign bus_if.write_addr = write_addr_q;
  assign bus_if.write_data = write_data_q;

endmodule

// File: tb/tb_wb_controller.sv
// Directed bench for wb_controller: expected writes are queued by the stimulus
// and matched by a monitor on every register-file write.
module tb_wb_controller;
  import wb_controller_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   wr_cnt;
  int   start_cnt;

  wb_entry_t exp_q [$];
  wb_entry_t exp_e;

  wb_controller_if bus ();

  wb_controller #(.DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every write seen on the register-file port must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && bus.reg_write) begin
      wr_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL write_unexpected: got addr %0d data %h, required no write",
                 bus.write_addr, bus.write_data);
      end else begin
        exp_e = exp_q.pop_front();
        if (bus.write_addr !== exp_e.addr || bus.write_data !== exp_e.data) begin
          n_errors++;
          $display("FAIL write_order: got addr %0d data %h, required addr %0d data %h",
                   bus.write_addr, bus.write_data, exp_e.addr, exp_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wb_entry_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      step();
      t++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_addr    = 5'd0;
    bus.alu_data    = 32'd0;
    bus.long_valid  = 1'b0;
    bus.long_addr   = 5'd0;
    bus.long_data   = 32'd0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = 5'd0;
    bus.read_addr1  = 5'd0;
    bus.read_addr2  = 5'd0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr_cnt   = 0;
    rst      = 1'b1;
    idle_inputs();
    step();
    step();
    chk("reset_regwrite",  32'(bus.reg_write),  32'd0);
    chk("reset_waddr",     32'(bus.write_addr), 32'd0);
    chk("reset_wdata",     bus.write_data,      32'd0);
    chk("reset_busy",      bus.busy,            32'd0);
    chk("reset_longready", 32'(bus.long_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("release_longready", 32'(bus.long_ready), 32'd1);
    step();

    // ALU only
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    bus.alu_valid = 1'b0;
    chk("alu_regwrite", 32'(bus.reg_write),  32'd1);
    chk("alu_waddr",    32'(bus.write_addr), 32'd5);
    wait_drain();

    // ALU priority over long results, back-to-back writes
    expect_wr(5'd3, 32'h0000_0033);
    expect_wr(5'd4, 32'h0000_0044);
    expect_wr(5'd5, 32'h0000_0055);
    expect_wr(5'd8, 32'h0000_0088);
    expect_wr(5'd9, 32'h0000_0099);
    start_cnt      = wr_cnt;
    bus.alu_valid  = 1'b1;
    bus.alu_addr   = 5'd3;
    bus.alu_data   = 32'h0000_0033;
    bus.long_valid = 1'b1;
    bus.long_addr  = 5'd8;
    bus.long_data  = 32'h0000_0088;
    step();
    bus.alu_addr   = 5'd4;
    bus.alu_data   = 32'h0000_0044;
    bus.long_addr  = 5'd9;
    bus.long_data  = 32'h0000_0099;
    step();
    bus.alu_addr   = 5'd5;
    bus.alu_data   = 32'h0000_0055;
    bus.long_valid = 1'b0;
    step();
    bus.alu_valid  = 1'b0;
    step();
    step();
    @(negedge clk);
    #1;
    chk("priority_no_gaps", 32'(wr_cnt - start_cnt), 32'd5);
    wait_drain();

    // Full FIFO under continuous ALU traffic
    bus.alu_valid  = 1'b1;
    bus.long_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.alu_addr  = 5'(20 + i);
      bus.alu_data  = 32'hA000_0000 + 32'(i);
      bus.long_addr = 5'(12 + i);
      bus.long_data = 32'hB000_0000 + 32'(i);
      expect_wr(5'(20 + i), 32'hA000_0000 + 32'(i));
      step();
    end
    chk("full_longready", 32'(bus.long_ready), 32'd0);
    bus.alu_addr  = 5'd24;
    bus.alu_data  = 32'hA000_0004;
    bus.long_addr = 5'd17;
    bus.long_data = 32'hB000_0017;
    expect_wr(5'd24, 32'hA000_0004);
    step();
    chk("full_held_longready", 32'(bus.long_ready), 32'd0);
    bus.alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_wr(5'(12 + i), 32'hB000_0000 + 32'(i));
    end
    expect_wr(5'd17, 32'hB000_0017);
    step();
    chk("after_pop_longready", 32'(bus.long_ready), 32'd1);
    step();
    bus.long_valid = 1'b0;
    wait_drain();

    // Scoreboard set, stall, clear, and set-wins-over-clear
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd7;
    step();
    bus.issue_valid = 1'b0;
    bus.read_addr1  = 5'd7;
    bus.read_addr2  = 5'd6;
    #1;
    chk("sb_busy_set",  bus.busy,            32'h0000_0080);
    chk("sb_stall_rd1", 32'(bus.stall),      32'd1);
    bus.read_addr1  = 5'd6;
    #1;
    chk("sb_no_stall",  32'(bus.stall),      32'd0);
    bus.read_addr2  = 5'd7;
    #1;
    chk("sb_stall_rd2", 32'(bus.stall),      32'd1);
    bus.read_addr1  = 5'd0;
    bus.read_addr2  = 5'd0;
    bus.long_valid  = 1'b1;
    bus.long_addr   = 5'd7;
    bus.long_data   = 32'h7777_0001;
    expect_wr(5'd7, 32'h7777_0001);
    step();
    bus.long_valid  = 1'b0;
    step();
    chk("sb_clear_busy",     bus.busy,           32'd0);
    chk("sb_clear_regwrite", 32'(bus.reg_write), 32'd1);
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    bus.long_valid  = 1'b1;
    bus.long_data   = 32'h7777_0002;
    expect_wr(5'd7, 32'h7777_0002);
    step();
    bus.long_valid  = 1'b0;
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    chk("sb_set_wins", bus.busy, 32'h0000_0080);
    bus.long_valid  = 1'b1;
    bus.long_data   = 32'h7777_0003;
    expect_wr(5'd7, 32'h7777_0003);
    step();
    bus.long_valid  = 1'b0;
    step();
    chk("sb_final_clear", bus.busy, 32'd0);
    wait_drain();

    // Address 0 results and issues
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd0;
    bus.alu_data  = 32'h0000_00A0;
    step();
    bus.alu_valid = 1'b0;
    chk("r0_alu_regwrite", 32'(bus.reg_write), 32'd0);
    chk("r0_alu_wdata",    bus.write_data,     32'h0000_00A0);
    bus.long_valid = 1'b1;
    bus.long_addr  = 5'd0;
    bus.long_data  = 32'h0000_00B0;
    step();
    bus.long_valid = 1'b0;
    step();
    chk("r0_long_regwrite", 32'(bus.reg_write), 32'd0);
    chk("r0_long_wdata",    bus.write_data,     32'h0000_00B0);
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd0;
    step();
    bus.issue_valid = 1'b0;
    chk("r0_issue_busy", bus.busy, 32'd0);

    // Mid-stream reset with three buffered entries and Busy = r2, r8
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd2;
    step();
    bus.issue_addr  = 5'd8;
    step();
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b1;
    bus.alu_addr    = 5'd0;
    bus.alu_data    = 32'h0000_CAFE;
    bus.long_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.long_addr = (i == 0) ? 5'd2 : ((i == 1) ? 5'd8 : 5'd10);
      bus.long_data = 32'hC000_0000 + 32'(i);
      step();
    end
    bus.long_valid  = 1'b0;
    chk("pre_reset_busy",      bus.busy,            32'h0000_0104);
    chk("pre_reset_longready", 32'(bus.long_ready), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_regwrite",  32'(bus.reg_write),  32'd0);
    chk("midrst_waddr",     32'(bus.write_addr), 32'd0);
    chk("midrst_wdata",     bus.write_data,      32'd0);
    chk("midrst_busy",      bus.busy,            32'd0);
    chk("midrst_longready", 32'(bus.long_ready), 32'd0);
    idle_inputs();
    step();
    rst = 1'b0;
    #1;
    chk("postrst_longready", 32'(bus.long_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
    end
    chk("postrst_busy",     bus.busy,           32'd0);
    chk("postrst_no_write", 32'(exp_q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_controller.md
# wb_controller

Write-back controller: the initiator that drives the register file's write port (RegWrite/WriteAddr/WriteData). It merges single-cycle ALU results with buffered results from long-latency units (mul/div, loads) into at most one register write per cycle. It also keeps a pending-destination scoreboard so the decode stage can stall on operands that are not yet written.

## Interface
- DEPTH, 4: long-result FIFO entries, a power of two of at least 2.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- AluValid  in  1  ALU result present this cycle; always accepted.
- AluAddr  in  5  ALU destination register.
- AluData  in  32  ALU result.
- LongValid  in  1  long-latency result offered.
- LongReady  out  1  FIFO can accept; equals not-full from the registered count.
- LongAddr  in  5  long-result destination.
- LongData  in  32  long result.
- IssueValid  in  1  a long-latency op is issued this cycle.
- IssueAddr  in  5  its destination; marks the register busy.
- ReadAddr1, ReadAddr2  in  5 each  decode operand addresses.
- Stall  out  1  an operand is busy.
- Busy  out  32  scoreboard vector.
- RegWrite  out  1  register-file write enable, registered.
- WriteAddr  out  5  register-file write address, registered.
- WriteData  out  32  register-file write data, registered.

## Operation
- Reset values: RegWrite=0, WriteAddr=0, WriteData=0, Busy=0, FIFO empty. LongReady=0 while Reset is high and 1 after.
- Long accept: LongValid && LongReady at a rising edge pushes {LongAddr, LongData}. When the FIFO is full, nothing is pushed, even if a pop happens in the same cycle.
- Selection each cycle, with the ALU having priority:
  - If AluValid: register the ALU result. The FIFO head holds.
  - Otherwise, if the FIFO is non-empty: pop the head and register it.
  - Otherwise: RegWrite=0.
- Address 0 results: the registered RegWrite is 0, so no write is issued. A long entry to address 0 is still popped. WriteAddr/WriteData still update.
- Scoreboard set: IssueValid with IssueAddr≠0 sets Busy[IssueAddr] at the edge.
- Scoreboard clear: a FIFO pop clears Busy[head address] at the same edge.
- Same-edge set and clear of one register: set wins, because a new issue supersedes the old one.
- ALU writes never touch Busy.
- Busy[0] is always 0.
- Stall = Busy[ReadAddr1] | Busy[ReadAddr2], combinational from the registered Busy. It does not look ahead to an issue in the same cycle.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits and ranges 0..DEPTH.

## Timing
- ALU path: accepted at edge N, RegWrite high in cycle N+1, register file updated at edge N+2.
- Long path with an empty FIFO and no ALU traffic: pushed at edge N, popped at edge N+1, RegWrite high in cycle N+2.
- Each FIFO pop lowers Busy one cycle before the register file holds the value. Decode must rely on forwarding from WriteData, or re-read one cycle later; the pipeline forwards from WriteData.
- Continuous AluValid starves the FIFO indefinitely. This is accepted behaviour; LongReady drops once the FIFO is full.
- Reset asserted mid-operation: all outputs return to reset values immediately, and FIFO contents and Busy are discarded.

## Structure
- Shared package: REG_ADDR_W=5, REG_DATA_W=32, DEPTH default, and the entry type {addr, data}.
- Sub-module wb_fifo(DEPTH): synchronous FIFO with push/pop, full/empty and head outputs. It uses the same Clock and Reset.
- wb_controller holds the priority mux, the output registers and the scoreboard.

## Test plan
- Reset: assert Reset mid-stream with a FIFO of 3 entries and Busy=0x0000_0104 -> all outputs 0 at once, LongReady=0. After release, LongReady=1 and the FIFO is empty.
- ALU only: AluValid, AluAddr=5, AluData=0xDEADBEEF at edge 0 -> RegWrite=1, WriteAddr=5, WriteData=0xDEADBEEF during cycle 1.
- Priority: ALU writes to 3,4,5 on consecutive cycles while long results to 8 and 9 are pushed -> writes appear in order 3,4,5,8,9 with no gaps.
- Full FIFO: DEPTH=4, 4 long pushes under continuous AluValid -> LongReady=0 and a 5th LongValid is held. After AluValid drops, all 4 entries drain in order.
- Scoreboard:
  - Issue to r7 -> Busy[7]=1, and Stall=1 with ReadAddr1=7.
  - Long result to r7 popped -> Busy[7]=0 at the same edge that RegWrite rises.
  - Issue to r7 on the same edge as the pop -> Busy[7] stays 1.
- Address 0: ALU write to r0 and long result to r0 -> RegWrite stays 0, the FIFO empties, and IssueAddr=0 leaves Busy=0.
